// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM sequencing fetch, decode,
// execute, memory access and writeback, with a retired-instruction counter.
//   clk, reset_n        clock and asynchronous active-low reset
//   opcode, funct       instruction fields (opcode valid from DECODE onward)
//   zero, mem_ready     ALU zero flag, memory access completes this cycle
//   alu_control/src_*   ALU operation and operand selects
//   pc_source, pc_en    PC next-value select and write strobe
//   iord, mem_read/write, ir_write, reg_write, reg_dst, mem_to_reg
//   halted, state       stop indication and debug view of the state register
//   instr_count         retired-instruction count, wraps modulo 2^COUNT_W
// Build option: define ILLEGAL_OPCODE_TRAP_EN to send unknown opcodes to TRAP
// instead of treating them as NOPs.
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               halted,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_XOR = 3'd4;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
    MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    I_EXEC = 4'd10, I_WB = 4'd11, HALT = 4'd12, TRAP = 4'd13
  } state_t;
  state_t r_state, w_next, w_dec;
  logic [COUNT_W-1:0] r_count;
  logic [2:0] w_alu_r;
  logic w_pc_en, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != FETCH && w_next == FETCH) r_count <= r_count + COUNT_W'(1);
    end
  always_comb begin
    w_dec = FETCH;
    case (opcode)
      6'h00:        w_dec = R_EXEC;
      6'h23, 6'h2B: w_dec = MEM_ADDR;
      6'h04, 6'h05: w_dec = BRANCH;
      6'h02:        w_dec = JUMP;
      6'h08:        w_dec = I_EXEC;
      6'h3F:        w_dec = HALT;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      default:      w_dec = TRAP;
`else
      default:      w_dec = FETCH;
`endif
    endcase
  end
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:      w_next = mem_ready ? DECODE : FETCH;
      DECODE:     w_next = w_dec;
      MEM_ADDR:   w_next = (opcode == 6'h2B) ? MEM_WRITE : MEM_READ;
      MEM_READ:   w_next = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE:  w_next = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:     w_next = R_WB;
      I_EXEC:     w_next = I_WB;
      HALT, TRAP: w_next = r_state;
      default:    w_next = FETCH;
    endcase
  end
  // Unlisted funct codes fall through to ADD rather than trapping.
  assign w_alu_r = (funct == 6'h22) ? ALU_SUB :
                   (funct == 6'h24) ? ALU_AND :
                   (funct == 6'h25) ? ALU_OR  :
                   (funct == 6'h26) ? ALU_XOR : ALU_ADD;
  assign alu_control = (r_state == BRANCH) ? ALU_SUB : (r_state == R_EXEC) ? w_alu_r : ALU_ADD;
  assign alu_src_a   = r_state inside {MEM_ADDR, R_EXEC, BRANCH, I_EXEC};
  assign alu_src_b   = (r_state == FETCH) ? 2'd1 : (r_state == DECODE) ? 2'd3 :
                       (r_state inside {MEM_ADDR, I_EXEC}) ? 2'd2 : 2'd0;
  assign pc_source   = (r_state == BRANCH) ? 2'd1 : (r_state == JUMP) ? 2'd2 : 2'd0;
  assign iord        = r_state inside {MEM_READ, MEM_WRITE};
  assign reg_dst     = r_state == R_WB;
  assign mem_to_reg  = r_state == MEM_WB;
  assign halted      = r_state inside {HALT, TRAP};
  // opcode[0] separates BNE (0x05) from BEQ (0x04).
  assign w_pc_en     = (r_state == FETCH) ? mem_ready :
                       (r_state == BRANCH) ? (opcode[0] ? ~zero : zero) : (r_state == JUMP);
  assign w_ir_write  = (r_state == FETCH) & mem_ready;
  assign w_mem_read  = r_state inside {FETCH, MEM_READ};
  assign w_mem_write = r_state == MEM_WRITE;
  assign w_reg_write = r_state inside {MEM_WB, R_WB, I_WB};
  // Strobes are gated directly by reset so they drop the instant reset asserts.
  assign pc_en       = reset_n & w_pc_en;
  assign ir_write    = reset_n & w_ir_write;
  assign mem_read    = reset_n & w_mem_read;
  assign mem_write   = reset_n & w_mem_write;
  assign reg_write   = reset_n & w_reg_write;
  assign state       = r_state;
  assign instr_count = r_count;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multicycle control FSM.
module tb_multicycle_control;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, XOR_ = 3'd4;
  localparam logic [3:0] S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5, S_RE = 6,
                         S_RWB = 7, S_BR = 8, S_J = 9, S_IE = 10, S_IWB = 11, S_H = 12, S_T = 13;
  logic clk = 0, reset_n = 0, zero = 0, mem_ready = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic [2:0] alu_control;
  logic alu_src_a, pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] state;
  logic [31:0] instr_count;
  int n_vec = 0, n_err = 0;
  logic [31:0] c = 0;
  typedef struct { logic [3:0] st; logic [16:0] outs; logic [31:0] cnt; } exp_t;
  exp_t sb[$];
  wire [16:0] act = {alu_control, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
                     mem_write, ir_write, reg_write, reg_dst, mem_to_reg, halted};

  multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted), .state(state),
    .instr_count(instr_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_out(input logic [3:0] s, input logic rdy, input logic rst_low);
    logic [2:0] alu;
    logic a, pe, io, mr, mw, ir, rw, rd, m2r, h;
    logic [1:0] b, pcs;
    alu = ADD; a = 0; b = 0; pcs = 0;
    {pe, io, mr, mw, ir, rw, rd, m2r, h} = '0;
    case (s)
      S_F:   begin mr = 1; b = 1; pe = rdy; ir = rdy; end
      S_D:   b = 3;
      S_MA:  begin a = 1; b = 2; end
      S_MR:  begin mr = 1; io = 1; end
      S_MWB: begin rw = 1; m2r = 1; end
      S_MW:  begin mw = 1; io = 1; end
      S_RE:  begin
        a = 1;
        case (funct)
          6'h22: alu = SUB;
          6'h24: alu = AND_;
          6'h25: alu = OR_;
          6'h26: alu = XOR_;
          default: alu = ADD;
        endcase
      end
      S_RWB: begin rw = 1; rd = 1; end
      S_BR:  begin a = 1; alu = SUB; pcs = 1; pe = (opcode == 6'h04) ? zero : !zero; end
      S_J:   begin pcs = 2; pe = 1; end
      S_IE:  begin a = 1; b = 2; end
      S_IWB: rw = 1;
      S_H, S_T: h = 1;
      default: ;
    endcase
    if (rst_low) {pe, ir, mr, mw, rw} = '0;
    return {alu, a, b, pcs, pe, io, mr, mw, ir, rw, rd, m2r, h};
  endfunction

  // Drive one cycle: push the expectation, then pop and compare mid-cycle.
  task automatic cyc(input logic [3:0] st, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    e.st = st; e.outs = ref_out(st, rdy, 1'b0); e.cnt = c;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check("state", 64'(state), 64'(e.st));
      check("outs", 64'(act), 64'(e.outs));
      check("count", 64'(instr_count), 64'(e.cnt));
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset_n = 0; mem_ready = 0;
    #1;
    check("rst_state", 64'(state), 64'(S_F));
    check("rst_outs", 64'(act), 64'(ref_out(S_F, 1'b0, 1'b1)));
    check("rst_count", 64'(instr_count), 0);
    c = 0;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] fl[6];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    #2;
    pulse_reset();
    // R-type through every funct, including an unmapped one
    foreach (fl[i]) begin
      opcode = 6'h00; funct = fl[i];
      cyc(S_F, 1); cyc(S_D, 1); cyc(S_RE, 1); cyc(S_RWB, 1); c++;
    end
    // LW with three memory wait cycles
    opcode = 6'h23;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_MA, 1);
    cyc(S_MR, 0); cyc(S_MR, 0); cyc(S_MR, 0); cyc(S_MR, 1); cyc(S_MWB, 1); c++;
    // SW with one fetch wait and one write wait
    opcode = 6'h2B;
    cyc(S_F, 0); cyc(S_F, 1); cyc(S_D, 1); cyc(S_MA, 1); cyc(S_MW, 0); cyc(S_MW, 1); c++;
    // BEQ/BNE with both zero values
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      opcode = 6'h04; cyc(S_F, 1); cyc(S_D, 1); cyc(S_BR, 1); c++;
      opcode = 6'h05; cyc(S_F, 1); cyc(S_D, 1); cyc(S_BR, 1); c++;
    end
    zero = 0;
    opcode = 6'h02; cyc(S_F, 1); cyc(S_D, 1); cyc(S_J, 1); c++;
    opcode = 6'h08; cyc(S_F, 1); cyc(S_D, 1); cyc(S_IE, 1); cyc(S_IWB, 1); c++;
    // Unrecognised opcode
    opcode = 6'h11;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_T, 1); cyc(S_T, 1); cyc(S_T, 0);
    pulse_reset();
`else
    cyc(S_F, 1); cyc(S_D, 1); c++;
`endif
    cyc(S_F, 0);
    // Reset asserted mid-MEM_READ wait
    opcode = 6'h23;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_MA, 1); cyc(S_MR, 0);
    #2;
    pulse_reset();
    opcode = 6'h08; cyc(S_F, 1); cyc(S_D, 1); cyc(S_IE, 1); cyc(S_IWB, 1); c++;
    // HALT is absorbing and freezes the count
    opcode = 6'h3F;
    cyc(S_F, 1); cyc(S_D, 1);
    for (int k = 0; k < 11; k++) cyc(S_H, k[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
